// File: rtl/chime_pkg.sv
// Shared constants for the hourly chime controller.
//   S_IDLE/S_ON/S_OFF : FSM state encodings
//   MODE_FIXED/MODE_HOUR : values of the MODE input
//   HOURS_FOLD : 12-hour fold used for clock-tower strike counts
package chime_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_OFF  = 2'd2;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_HOUR  = 1'b1;

  localparam int unsigned HOURS_FOLD = 12;

endpackage

// File: rtl/chime_ctrl_bcd_hour_to_strikes.sv
// Combinational strike-count selector.
//   HOUR    : BCD hour {tens, ones}, valid 00..23
//   MODE    : MODE_FIXED -> FIXED_BEEPS, MODE_HOUR -> hour folded to 1..12
//   strikes : number of beeps to play; invalid hours fall back to FIXED_BEEPS
module bcd_hour_to_strikes
  import chime_pkg::*;
#(
  parameter int unsigned FIXED_BEEPS = 4
) (
  input  logic [7:0] HOUR,
  input  logic       MODE,
  output logic [3:0] strikes
);

  localparam logic [3:0] FIXED4 = 4'(FIXED_BEEPS);
  localparam logic [6:0] FOLD7  = 7'(HOURS_FOLD);

  logic [3:0] tens;
  logic [3:0] ones;
  logic [6:0] hbin;
  logic [6:0] folded;
  logic       valid;

  always_comb begin
    tens   = HOUR[7:4];
    ones   = HOUR[3:0];
    hbin   = 7'(tens) * 7'd10 + 7'(ones);
    valid  = (tens <= 4'd9) && (ones <= 4'd9) && (hbin <= 7'd23);
    folded = (hbin >= FOLD7) ? (hbin - FOLD7) : hbin;

    strikes = FIXED4;
    if (MODE == MODE_HOUR && valid) begin
      // Midnight and noon strike twelve rather than zero.
      strikes = (folded == 7'd0) ? FOLD7[3:0] : folded[3:0];
    end
  end

endmodule

// File: rtl/chime_ctrl.sv
// On-the-hour chime controller.
//   CP        : system clock (rising edge)
//   CR        : synchronous active-high reset
//   EN        : chime enable; low aborts a pattern or blocks a new one
//   TICK      : one-cycle pacing strobe
//   HOUR_TRIG : one-cycle hour-rollover pulse
//   HOUR      : BCD hour, sampled at the trigger edge
//   MODE      : 0 fixed beep count, 1 hour strike count
//   BEEP      : buzzer drive, high in the ON phase
//   LEDZ      : toggles at the start of each beep
//   BUSY      : high while a pattern runs
//   DONE      : one-cycle pulse on normal completion
module chime_ctrl
  import chime_pkg::*;
#(
  parameter int unsigned ON_TICKS    = 2,
  parameter int unsigned OFF_TICKS   = 2,
  parameter int unsigned FIXED_BEEPS = 4,
  parameter int unsigned TW          = 4
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       EN,
  input  logic       TICK,
  input  logic       HOUR_TRIG,
  input  logic [7:0] HOUR,
  input  logic       MODE,
  output logic       BEEP,
  output logic       LEDZ,
  output logic       BUSY,
  output logic       DONE
);

  localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_TICKS - 1);

  logic [1:0]    state;
  logic [TW-1:0] tick_cnt;
  logic [3:0]    remaining;
  logic [3:0]    strikes;

  bcd_hour_to_strikes #(
    .FIXED_BEEPS(FIXED_BEEPS)
  ) u_strikes (
    .HOUR    (HOUR),
    .MODE    (MODE),
    .strikes (strikes)
  );

  always_ff @(posedge CP) begin
    if (CR) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      remaining <= '0;
      LEDZ      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          // A TICK coinciding with the trigger is deliberately not counted.
          if (HOUR_TRIG && EN) begin
            state     <= S_ON;
            remaining <= strikes;
            tick_cnt  <= '0;
            LEDZ      <= ~LEDZ;
          end
        end
        S_ON: begin
          if (!EN) begin
            state    <= S_IDLE;
            tick_cnt <= '0;
          end else if (TICK) begin
            if (tick_cnt == ON_LAST) begin
              tick_cnt  <= '0;
              remaining <= remaining - 4'd1;
              if (remaining == 4'd1) begin
                state <= S_IDLE;
                DONE  <= 1'b1;
              end else begin
                state <= S_OFF;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        S_OFF: begin
          if (!EN) begin
            state    <= S_IDLE;
            tick_cnt <= '0;
          end else if (TICK) begin
            if (tick_cnt == OFF_LAST) begin
              state    <= S_ON;
              tick_cnt <= '0;
              LEDZ     <= ~LEDZ;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    BEEP = (state == S_ON);
    BUSY = (state != S_IDLE);
  end

endmodule

// File: tb/tb_chime_ctrl.sv
module tb_chime_ctrl;

  logic       CP = 1'b0;
  logic       CR, EN, TICK, HOUR_TRIG, MODE;
  logic [7:0] HOUR;
  logic       BEEP, LEDZ, BUSY, DONE;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  chime_ctrl #(
    .ON_TICKS(2),
    .OFF_TICKS(2),
    .FIXED_BEEPS(4),
    .TW(4)
  ) dut (
    .CP(CP), .CR(CR), .EN(EN), .TICK(TICK), .HOUR_TRIG(HOUR_TRIG),
    .HOUR(HOUR), .MODE(MODE), .BEEP(BEEP), .LEDZ(LEDZ), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CP = ~CP;

  typedef struct {
    logic       mode;
    logic [7:0] hour;
    int         beeps;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Sample at the falling edge, then set up inputs for the next rising edge.
  // TICK is a free-running strobe every 4 clocks.
  task automatic cycle();
    @(negedge CP);
    cyc++;
    TICK = (cyc % 4 == 0);
  endtask

  // Strike count from the rules: fixed count, or hour mod 12 with 0 -> 12,
  // falling back to the fixed count for anything that isn't a valid hour.
  function automatic int ref_strikes(input logic m, input logic [7:0] h);
    int t, o, hr;
    t = int'(h) / 16;
    o = int'(h) % 16;
    if (m == 1'b0) return 4;
    if (t > 9 || o > 9) return 4;
    hr = t * 10 + o;
    if (hr > 23) return 4;
    return (hr % 12 == 0) ? 12 : hr % 12;
  endfunction

  // Fire one trigger aligned with a TICK and watch the whole pattern.
  // retrig > 0 re-pulses HOUR_TRIG (with a different hour) when that beep starts.
  task automatic run_pattern(input string nm, input logic m, input logic [7:0] h,
                             input int exp_beeps, input int retrig);
    int nb, ntog, nd, on_run, off_run, bad_on, bad_off, n;
    logic pb, pl, l0;
    bit ended;
    n = 0;
    while (!TICK && n < 8) begin
      cycle();
      n++;
    end
    l0 = LEDZ; pl = LEDZ; pb = 1'b0;
    MODE = m; HOUR = h; HOUR_TRIG = 1'b1;
    nb = 0; ntog = 0; nd = 0; on_run = 0; off_run = 0; bad_on = 0; bad_off = 0;
    ended = 1'b0;
    for (int c = 0; c < 600 && !ended; c++) begin
      cycle();
      HOUR_TRIG = 1'b0;
      if (DONE) nd++;
      if (LEDZ != pl) ntog++;
      if (BEEP && !pb) begin
        nb++;
        if (nb > 1 && off_run != 8) bad_off++;
        off_run = 0;
        if (nb == retrig) begin
          HOUR_TRIG = 1'b1; MODE = 1'b1; HOUR = 8'h13;
        end
      end
      if (!BEEP && pb) begin
        if (on_run != 8) bad_on++;
        on_run = 0;
      end
      if (BEEP) on_run++; else off_run++;
      if (!BUSY) ended = 1'b1;
      pb = BEEP; pl = LEDZ;
    end
    check({nm, " completes"}, int'(ended), 1);
    cycle();
    if (DONE) nd++;
    check({nm, " beeps"}, nb, exp_beeps);
    check({nm, " led_toggles"}, ntog, exp_beeps);
    check({nm, " done_pulses"}, nd, 1);
    check({nm, " on_len_errs"}, bad_on, 0);
    check({nm, " off_len_errs"}, bad_off, 0);
    check({nm, " led_final"}, int'(LEDZ), int'(l0 ^ exp_beeps[0]));
  endtask

  task automatic wait_beep(input logic val, input string nm);
    int n;
    n = 0;
    while (BEEP !== val && n < 100) begin
      cycle();
      n++;
    end
    check({nm, " wait_beep"}, int'(BEEP === val), 1);
  endtask

  initial begin
    logic led;
    logic [7:0] h;
    logic m;
    int exp, dn, bz;

    CR = 1'b1; EN = 1'b1; TICK = 1'b0; HOUR_TRIG = 1'b0; MODE = 1'b0; HOUR = 8'h00;
    repeat (3) cycle();
    check("reset BEEP", int'(BEEP), 0);
    check("reset LEDZ", int'(LEDZ), 0);
    check("reset BUSY", int'(BUSY), 0);
    check("reset DONE", int'(DONE), 0);
    CR = 1'b0;
    repeat (3) cycle();

    tbl[0] = '{1'b0, 8'h07, 4};
    tbl[1] = '{1'b1, 8'h15, 3};
    tbl[2] = '{1'b1, 8'h00, 12};
    tbl[3] = '{1'b1, 8'h12, 12};
    tbl[4] = '{1'b1, 8'h13, 1};
    tbl[5] = '{1'b1, 8'h2A, 4};
    tbl[6] = '{1'b1, 8'h25, 4};
    tbl[7] = '{1'b1, 8'h23, 11};
    for (int i = 0; i < 8; i++) begin
      run_pattern($sformatf("vec%0d", i), tbl[i].mode, tbl[i].hour, tbl[i].beeps, 0);
      repeat (5) cycle();
    end

    // Retrigger during beep 2 must not restart or change the count.
    run_pattern("retrig", 1'b0, 8'h05, 4, 2);
    repeat (5) cycle();

    // Abort in OFF.
    MODE = 1'b0; HOUR_TRIG = 1'b1;
    cycle();
    HOUR_TRIG = 1'b0;
    wait_beep(1'b1, "abort");
    wait_beep(1'b0, "abort");
    check("abort in_off BUSY", int'(BUSY), 1);
    led = LEDZ;
    EN = 1'b0;
    cycle();
    check("abort BEEP", int'(BEEP), 0);
    check("abort BUSY", int'(BUSY), 0);
    check("abort DONE", int'(DONE), 0);
    check("abort LEDZ", int'(LEDZ), int'(led));
    EN = 1'b1;
    dn = 0; bz = 0;
    repeat (40) begin
      cycle();
      if (DONE) dn++;
      if (BUSY) bz++;
    end
    check("abort no_done", dn, 0);
    check("abort stays_idle", bz, 0);

    // Trigger with EN low.
    led = LEDZ;
    EN = 1'b0; HOUR_TRIG = 1'b1;
    cycle();
    HOUR_TRIG = 1'b0;
    cycle();
    check("en_low BUSY", int'(BUSY), 0);
    check("en_low BEEP", int'(BEEP), 0);
    check("en_low LEDZ", int'(LEDZ), int'(led));
    EN = 1'b1;
    repeat (3) cycle();

    // Reset in the middle of a beep.
    MODE = 1'b0; HOUR_TRIG = 1'b1;
    cycle();
    HOUR_TRIG = 1'b0;
    cycle();
    check("midreset pre BEEP", int'(BEEP), 1);
    CR = 1'b1;
    cycle();
    check("midreset BEEP", int'(BEEP), 0);
    check("midreset LEDZ", int'(LEDZ), 0);
    check("midreset BUSY", int'(BUSY), 0);
    check("midreset DONE", int'(DONE), 0);
    CR = 1'b0;
    cycle();
    run_pattern("after_reset", 1'b0, 8'h09, 4, 0);

    // Randomised hours and modes against the rule-based model.
    for (int i = 0; i < 20; i++) begin
      m = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        exp = int'($urandom_range(0, 23));
        h = {4'(exp / 10), 4'(exp % 10)};
      end else begin
        h = 8'($urandom);
      end
      exp = ref_strikes(m, h);
      run_pattern($sformatf("rand%0d m=%0d h=%02h", i, m, h), m, h, exp, 0);
      repeat (int'($urandom_range(1, 6))) cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
